sw_hex_multi: RTL and testbench

- Parametrised successor to the fixed SW-to-HEX demo path for DE-series boards.
- Captures the SW value on a debounced KEY press and converts it to hexadecimal (one cycle) or decimal (iterative double-dabble).
- Drives NUM_HEX active-low 7-segment displays with leading-zero blanking and overflow indication.
- Sits between board I/O (CLOCK_50, KEY, SW) and the HEX outputs inside top.

---
 rtl/sw_hex_pkg.sv | 26 ++
 rtl/key_debounce.sv | 28 ++
 rtl/sw_hex_multi.sv | 140 ++++++++++++++
 tb/tb_sw_hex_multi.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sw_hex_pkg.sv
// sw_hex_pkg: shared FSM state type and 7-segment encodings for sw_hex_multi.
package sw_hex_pkg;
  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_e;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus stable-low counter; one press pulse per press.
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Counter saturates at DEB_CYCLES so holding the key cannot re-trigger.
  always_comb begin
    sync_d = {sync_q[0], key_n};
    cnt_d = sync_q[1] ? '0 : (cnt_q == CW'(DEB_CYCLES)) ? cnt_q : cnt_q + 1'b1;
  end
  assign press = (cnt_d == CW'(DEB_CYCLES)) && (cnt_q != CW'(DEB_CYCLES));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/sw_hex_multi.sv
// sw_hex_multi: latches SW on a debounced press and shows it in hex or decimal on NUM_HEX digits.
// Define SW_HEX_MULTI_BLINK_EN to add the blink input that periodically blanks the display.
module sw_hex_multi
  import sw_hex_pkg::*;
#(
  parameter int SW_W       = 10,
  parameter int NUM_HEX    = 6,
  parameter int DEB_CYCLES = 500000,
  parameter int BLINK_HALF = 12500000
) (
  input  logic                 CLOCK_50,
  input  logic                 Resetn,
  input  logic [SW_W-1:0]      SW,
  input  logic                 KEY_load,
  input  logic                 mode_dec,
`ifdef SW_HEX_MULTI_BLINK_EN
  input  logic                 blink,
`endif
  output logic [7*NUM_HEX-1:0] HEX,
  output logic                 busy,
  output logic                 ovf
);
  localparam int B  = 4 * NUM_HEX;
  localparam int VW = (SW_W > B) ? SW_W : B;
  localparam int CW = $clog2(SW_W + 1);
  state_e state_q, state_d;
  logic [SW_W-1:0] val_q, val_d;
  logic mode_q, mode_d;
  logic [B-1:0] bcd_q, bcd_d, adj;
  logic sat_q, sat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7*NUM_HEX-1:0] hex_q, hex_d, disp;
  logic ovf_q, ovf_d;
  logic [VW-1:0] ext;
  logic press, load, seen;
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk(CLOCK_50),
    .rst_n(Resetn),
    .key_n(KEY_load),
    .press(press)
  );
  assign ext = VW'(SW);
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_HEX; i++)
      adj[4*i+:4] = (bcd_q[4*i+:4] >= 4'd5) ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end
  // Scan from the top digit down so blanking stops at the first nonzero digit.
  always_comb begin
    seen = 1'b0;
    disp = '0;
    for (int i = NUM_HEX - 1; i >= 0; i--) begin
      seen = seen | (bcd_q[4*i+:4] != 4'd0) | (i == 0);
      disp[7*i+:7] = sat_q ? SEG_DASH : seen ? seg7(bcd_q[4*i+:4]) : SEG_BLANK;
    end
  end
  // Hex mode fills the digit register at latch time, so its single CONV cycle also publishes.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    mode_d  = mode_q;
    bcd_d   = bcd_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (press) begin
        state_d = CONV;
        val_d   = SW;
        mode_d  = mode_dec;
        cnt_d   = '0;
        bcd_d   = mode_dec ? '0 : ext[B-1:0];
        sat_d   = mode_dec ? 1'b0 : |(ext >> B);
      end
      CONV: if (!mode_q) begin
        state_d = IDLE;
        load    = 1'b1;
      end else begin
        bcd_d   = {adj[B-2:0], val_q[SW_W-1]};
        sat_d   = sat_q | adj[B-1];
        val_d   = val_q << 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(SW_W - 1)) ? UPDATE : CONV;
      end
      default: begin
        state_d = IDLE;
        load    = 1'b1;
      end
    endcase
    hex_d = load ? disp : hex_q;
    ovf_d = load ? sat_q : ovf_q;
  end
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      val_q   <= '0;
      mode_q  <= 1'b0;
      bcd_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      hex_q   <= '1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      mode_q  <= mode_d;
      bcd_q   <= bcd_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy = state_q != IDLE;
  assign ovf  = ovf_q;
`ifdef SW_HEX_MULTI_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF + 1);
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic phase_q, phase_d;
  always_comb begin
    bcnt_d  = (bcnt_q == BW'(BLINK_HALF - 1)) ? '0 : bcnt_q + 1'b1;
    phase_d = phase_q ^ (bcnt_q == BW'(BLINK_HALF - 1));
  end
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end
  assign HEX = (blink && phase_q) ? '1 : hex_q;
`else
  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("BLINK_HALF must be positive");
  end
  assign HEX = hex_q;
`endif
endmodule

// File: tb/tb_sw_hex_multi.sv
// tb_sw_hex_multi: directed and random presses on 6-digit and 2-digit instances against an arithmetic model.
module tb_sw_hex_multi;
  logic CLOCK_50 = 1'b0;
  logic Resetn = 1'b0;
  logic [9:0] SW = '0;
  logic KEY_load = 1'b1;
  logic mode_dec = 1'b0;
  logic [41:0] hex6;
  logic [13:0] hex2;
  logic busy6, busy2, ovf6, ovf2;
  int checks = 0;
  int fails = 0;
  logic [6:0] segs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 CLOCK_50 = ~CLOCK_50;

  sw_hex_multi #(.SW_W(10), .NUM_HEX(6), .DEB_CYCLES(4)) dut6 (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .SW(SW), .KEY_load(KEY_load),
    .mode_dec(mode_dec), .HEX(hex6), .busy(busy6), .ovf(ovf6)
  );
  sw_hex_multi #(.SW_W(10), .NUM_HEX(2), .DEB_CYCLES(4)) dut2 (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .SW(SW), .KEY_load(KEY_load),
    .mode_dec(mode_dec), .HEX(hex2), .busy(busy2), .ovf(ovf2)
  );

  function automatic logic model_ovf(input int v, input bit dec, input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p *= (dec ? 10 : 16);
    return v >= p;
  endfunction

  function automatic logic [41:0] model_hex(input int v, input bit dec, input int n);
    int base;
    longint p;
    logic [41:0] r;
    base = dec ? 10 : 16;
    p = 1;
    r = '1;
    for (int i = 0; i < n; i++) begin
      r[7*i+:7] = (i > 0 && v < p) ? 7'h7F : segs[int'((v / p) % base)];
      p *= base;
    end
    if (v >= p)
      for (int i = 0; i < n; i++) r[7*i+:7] = 7'h3F;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives up to two low windows on KEY_load, watches both DUTs, then checks against the model.
  task automatic run(input string tag, input logic [9:0] sw, input logic md,
                     input int s1, input int l1, input int s2, input int l2,
                     input int cyc, input int exp_rises);
    int r6, r2, len6, len2, rise6, rise2, chg6, chg2, explen;
    logic b6p, b2p;
    logic [41:0] p6, e6, t2;
    logic [13:0] p2, e2;
    r6 = 0; r2 = 0; len6 = 0; len2 = 0;
    rise6 = -1; rise2 = -1; chg6 = -1; chg2 = -1;
    p6 = hex6; p2 = hex2; b6p = busy6; b2p = busy2;
    SW = sw;
    mode_dec = md;
    for (int c = 0; c < cyc; c++) begin
      KEY_load = !((c >= s1 && c < s1 + l1) || (c >= s2 && c < s2 + l2));
      @(negedge CLOCK_50);
      if (busy6 && !b6p) begin
        r6++;
        rise6 = c;
        SW = 10'($urandom);
        mode_dec = 1'($urandom);
      end
      if (busy2 && !b2p) begin
        r2++;
        rise2 = c;
      end
      len6 += busy6 ? 1 : 0;
      len2 += busy2 ? 1 : 0;
      if (chg6 < 0 && hex6 !== p6) chg6 = c;
      if (chg2 < 0 && hex2 !== p2) chg2 = c;
      b6p = busy6;
      b2p = busy2;
    end
    KEY_load = 1'b1;
    e6 = model_hex(int'(sw), md, 6);
    t2 = model_hex(int'(sw), md, 2);
    e2 = t2[13:0];
    explen = exp_rises == 0 ? 0 : (md ? 11 : 1);
    chk({tag, ":rises6"}, r6, exp_rises);
    chk({tag, ":rises2"}, r2, exp_rises);
    chk({tag, ":busylen6"}, len6, explen);
    chk({tag, ":busylen2"}, len2, explen);
    if (exp_rises == 0) begin
      chk({tag, ":hex6_kept"}, hex6, p6);
    end else begin
      chk({tag, ":hex6"}, hex6, e6);
      chk({tag, ":ovf6"}, ovf6, model_ovf(int'(sw), md, 6));
      chk({tag, ":hex2"}, hex2, e2);
      chk({tag, ":ovf2"}, ovf2, model_ovf(int'(sw), md, 2));
      if (e6 !== p6) chk({tag, ":lat6"}, chg6 - rise6, explen);
      if (e2 !== p2) chk({tag, ":lat2"}, chg2 - rise2, explen);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge CLOCK_50);
    chk("rst:hex6", hex6, {42{1'b1}});
    chk("rst:hex2", hex2, {14{1'b1}});
    chk("rst:busy", busy6, 1'b0);
    chk("rst:ovf", ovf6, 1'b0);
    Resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    chk("idle:hex6", hex6, {42{1'b1}});
    run("short", 10'd5, 1'b0, 1, 3, 0, 0, 20, 0);
    run("d1023", 10'd1023, 1'b1, 1, 8, 0, 0, 30, 1);
    run("h3fa", 10'h3FA, 1'b0, 1, 8, 0, 0, 30, 1);
    run("h255", 10'd255, 1'b0, 1, 8, 0, 0, 30, 1);
    run("d255", 10'd255, 1'b1, 1, 8, 0, 0, 30, 1);
    run("zero", 10'd0, 1'b0, 1, 8, 0, 0, 30, 1);
    run("dbl", 10'd77, 1'b1, 1, 6, 9, 6, 40, 1);
    run("hold", 10'h123, 1'b0, 1, 100, 0, 0, 130, 1);
    for (int k = 0; k < 16; k++)
      run("rand", 10'($urandom), 1'($urandom), 1, 8, 0, 0, 30, 1);
    SW = 10'd999;
    mode_dec = 1'b1;
    KEY_load = 1'b0;
    n = 0;
    while (!busy6 && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("rstconv:busy_seen", busy6, 1'b1);
    repeat (3) @(negedge CLOCK_50);
    KEY_load = 1'b1;
    #1 Resetn = 1'b0;
    #1;
    chk("rstconv:hex6", hex6, {42{1'b1}});
    chk("rstconv:hex2", hex2, {14{1'b1}});
    chk("rstconv:busy", busy6, 1'b0);
    chk("rstconv:ovf2", ovf2, 1'b0);
    @(negedge CLOCK_50);
    Resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    run("d999", 10'd999, 1'b1, 1, 8, 0, 0, 30, 1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
